down_counter: RTL and testbench



---
 rtl/down_counter.sv | 61 ++++++
 tb/tb_down_counter.sv | 107 ++++++++++
 2 files changed

// File: rtl/down_counter.sv
// down_counter
//   N-bit synchronous down-counter with count enable, parallel load, a
//   zero flag and a one-cycle wrap pulse. Serves as a free-running
//   modulo-2^N counter (en=1, load=0), a timeout timer, or an event divider.
//
// Parameters
//   N     counter width in bits (N >= 1)
//   INIT  value forced into out by reset (default all ones)
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       synchronous reset, active low
//   out       registered count
//   en        count enable (decrement when 1)
//   load      parallel load strobe; has priority over en
//   load_val  value written to out when load=1
//   zero      combinational, 1 when out == 0
//   wrap      registered pulse, 1 in the cycle out shows all-ones after
//             counting down from 0
//
// Edge priority: reset > load > count > hold.
module down_counter #(
  parameter int unsigned   N    = 2,
  parameter logic [N-1:0]  INIT = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] out,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic         zero,
  output logic         wrap
);

  logic         at_zero;
  logic [N-1:0] dec_val;

  assign at_zero = (out == '0);
  // Borrow discarded: 0 - 1 becomes all ones, so every one of the 2^N
  // states is visited.
  assign dec_val = out - {{(N-1){1'b0}}, 1'b1};
  assign zero    = at_zero;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out  <= INIT;
      wrap <= 1'b0;
    end else if (load) begin
      // A load never raises wrap, even when load_val is all ones.
      out  <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      out  <= dec_val;
      wrap <= at_zero;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;
  localparam int N = 2;
  localparam logic [N-1:0] INIT = {N{1'b1}};

  typedef struct packed {
    logic [N-1:0] out;
    logic         wrap;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] out;
  logic         zero;
  logic         wrap;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [N-1:0] m_out;
  logic         m_wrap;

  down_counter #(.N(N), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .out(out), .en(en), .load(load),
    .load_val(load_val), .zero(zero), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs, push the reference result, then compare the
  // DUT once the edge has settled.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [N-1:0] lv, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = l; load_val = lv;
    if (!r) begin
      m_out = INIT; m_wrap = 1'b0;
    end else if (l) begin
      m_out = lv; m_wrap = 1'b0;
    end else if (e) begin
      m_wrap = (m_out == '0);
      m_out  = (m_out == '0) ? {N{1'b1}} : m_out - 1'b1;
    end else begin
      m_wrap = 1'b0;
    end
    sb.push_back('{out: m_out, wrap: m_wrap, zero: (m_out == '0)});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert (out === x.out) else begin
      errors++;
      $error("FAIL %s out got=%0d exp=%0d", tag, out, x.out);
    end
    checks++;
    assert (wrap === x.wrap) else begin
      errors++;
      $error("FAIL %s wrap got=%0b exp=%0b", tag, wrap, x.wrap);
    end
    checks++;
    assert (zero === x.zero) else begin
      errors++;
      $error("FAIL %s zero got=%0b exp=%0b", tag, zero, x.zero);
    end
  endtask

  initial begin
    m_out = 'x; m_wrap = 1'b0;
    // Reset dominates en and load, and holds while low.
    step(1'b0, 1'b1, 1'b1, 2'd0, "reset0");
    step(1'b0, 1'b1, 1'b1, 2'd2, "reset1");
    // Free-run: 2,1,0,3,2,1,0,3
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 2'd0, "freerun");
    // Enable gating from 2.
    step(1'b1, 1'b1, 1'b0, 2'd0, "to2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0, "hold");
    step(1'b1, 1'b1, 1'b0, 2'd0, "reen");
    // Load beats en at out=1.
    step(1'b1, 1'b1, 1'b1, 2'd3, "loadprio");
    step(1'b1, 1'b1, 1'b0, 2'd0, "afterload");
    // Load 0, then wrap by counting.
    step(1'b1, 1'b0, 1'b1, 2'd0, "load0");
    step(1'b1, 1'b1, 1'b0, 2'd0, "wrapcnt");
    step(1'b1, 1'b1, 1'b0, 2'd0, "postwrap");
    // Loading all ones from 0 must not pulse wrap.
    step(1'b1, 1'b0, 1'b1, 2'd0, "load0b");
    step(1'b1, 1'b1, 1'b1, 2'd3, "loadones");
    // Reset mid-operation at out=0 with a wrap pending.
    step(1'b1, 1'b1, 1'b0, 2'd0, "cnt2");
    step(1'b1, 1'b1, 1'b0, 2'd0, "cnt1");
    step(1'b1, 1'b1, 1'b0, 2'd0, "cnt0");
    step(1'b0, 1'b1, 1'b1, 2'd1, "midreset");
    step(1'b1, 1'b1, 1'b0, 2'd0, "resume2");
    step(1'b1, 1'b1, 1'b0, 2'd0, "resume1");
    // Mixed random traffic against the reference model.
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0), N'($urandom_range(0, 3)), "rand");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
